// File: rtl/dbchecker_rd_splitter.sv
// AXI read splitter: breaks INCR bursts into sub-bursts of at most MAX_BEATS beats that never
// cross a 4 KB boundary. Define RD_SPLITTER_STATS_EN to add burst/split counters.
module dbchecker_rd_splitter #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_axi_ar_valid,
  output logic              s_axi_ar_ready,
  input  logic [ADDR_W-1:0] s_axi_ar_bits_addr,
  input  logic [7:0]        s_axi_ar_bits_len,
  input  logic [2:0]        s_axi_ar_bits_size,
  input  logic [1:0]        s_axi_ar_bits_burst,
  input  logic [3:0]        s_axi_ar_bits_cache,
  input  logic [2:0]        s_axi_ar_bits_prot,
  input  logic [3:0]        s_axi_ar_bits_qos,
  input  logic              s_axi_ar_bits_lock,
  output logic              s_axi_r_valid,
  input  logic              s_axi_r_ready,
  output logic [DATA_W-1:0] s_axi_r_bits_data,
  output logic [1:0]        s_axi_r_bits_resp,
  output logic              s_axi_r_bits_last,
  output logic              m_axi_ar_valid,
  input  logic              m_axi_ar_ready,
  output logic [ADDR_W-1:0] m_axi_ar_bits_addr,
  output logic [7:0]        m_axi_ar_bits_len,
  output logic [2:0]        m_axi_ar_bits_size,
  output logic [1:0]        m_axi_ar_bits_burst,
  output logic [3:0]        m_axi_ar_bits_cache,
  output logic [2:0]        m_axi_ar_bits_prot,
  output logic [3:0]        m_axi_ar_bits_qos,
  output logic              m_axi_ar_bits_lock,
  input  logic              m_axi_r_valid,
  output logic              m_axi_r_ready,
  input  logic [DATA_W-1:0] m_axi_r_bits_data,
  input  logic [1:0]        m_axi_r_bits_resp,
  input  logic              m_axi_r_bits_last
`ifdef RD_SPLITTER_STATS_EN
  ,
  output logic [31:0]       stat_bursts,
  output logic [31:0]       stat_splits
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [8:0] MaxBeats  = 9'(MAX_BEATS);

  logic [1:0]        state_q, state_d;
  logic              init_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [3:0]        cache_q, qos_q;
  logic [2:0]        prot_q;
  logic              lock_q;

  logic              ar_hs, issue_hs, r_last_hs, in_data;
  logic [11:0]       aligned12;
  logic [12:0]       bnd;
  logic [8:0]        bnd9, beats;
  logic [ADDR_W-1:0] addr_mask;

  // Beats left before the next 4 KB page, counted from the size-aligned address.
  assign aligned12 = addr_q[11:0] & ~((12'd1 << size_q) - 12'd1);
  assign bnd       = (13'd4096 - {1'b0, aligned12}) >> size_q;
  assign bnd9      = (bnd > 13'd256) ? 9'd256 : 9'(bnd);
  assign addr_mask = (ADDR_W'(1) << size_q) - ADDR_W'(1);

  always_comb begin
    beats = rem_q;
    if (burst_q == BurstIncr) begin
      if (beats > MaxBeats) beats = MaxBeats;
      if (beats > bnd9)     beats = bnd9;
    end
  end

  assign in_data   = (state_q == StData);
  assign ar_hs     = s_axi_ar_valid & s_axi_ar_ready;
  assign issue_hs  = m_axi_ar_valid & m_axi_ar_ready;
  assign r_last_hs = in_data & m_axi_r_valid & s_axi_r_ready & m_axi_r_bits_last;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: if (ar_hs) begin
        state_d = StIssue;
        addr_d  = s_axi_ar_bits_addr;
        rem_d   = {1'b0, s_axi_ar_bits_len} + 9'd1;
      end
      StIssue: if (issue_hs) begin
        state_d = StData;
        rem_d   = rem_q - beats;
        addr_d  = (addr_q & ~addr_mask) + (ADDR_W'(beats) << size_q);
      end
      StData: if (r_last_hs) state_d = (rem_q != 9'd0) ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cache_q <= '0;
      prot_q  <= '0;
      qos_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      if (ar_hs) begin
        size_q  <= s_axi_ar_bits_size;
        burst_q <= s_axi_ar_bits_burst;
        cache_q <= s_axi_ar_bits_cache;
        prot_q  <= s_axi_ar_bits_prot;
        qos_q   <= s_axi_ar_bits_qos;
        lock_q  <= s_axi_ar_bits_lock;
      end
    end
  end

  // init_q keeps ar_ready low until the first edge after reset release.
  assign s_axi_ar_ready = init_q & (state_q == StIdle);

  assign m_axi_ar_valid      = (state_q == StIssue);
  assign m_axi_ar_bits_addr  = addr_q;
  assign m_axi_ar_bits_len   = 8'(beats - 9'd1);
  assign m_axi_ar_bits_size  = size_q;
  assign m_axi_ar_bits_burst = burst_q;
  assign m_axi_ar_bits_cache = cache_q;
  assign m_axi_ar_bits_prot  = prot_q;
  assign m_axi_ar_bits_qos   = qos_q;
  assign m_axi_ar_bits_lock  = lock_q;

  assign s_axi_r_valid     = in_data & m_axi_r_valid;
  assign m_axi_r_ready     = in_data & s_axi_r_ready;
  assign s_axi_r_bits_data = m_axi_r_bits_data;
  assign s_axi_r_bits_resp = m_axi_r_bits_resp;
  assign s_axi_r_bits_last = m_axi_r_bits_last & (rem_q == 9'd0);

`ifdef RD_SPLITTER_STATS_EN
  logic [31:0] bursts_q, splits_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bursts_q <= '0;
      splits_q <= '0;
    end else begin
      if (ar_hs)    bursts_q <= bursts_q + 32'd1;
      if (issue_hs) splits_q <= splits_q + 32'd1;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_splits = splits_q;
`endif

endmodule

// File: tb/tb_dbchecker_rd_splitter.sv
// Directed bench for dbchecker_rd_splitter: acts as both the upstream DMA and downstream slave.
module tb_dbchecker_rd_splitter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;
  localparam logic [127:0] DataBase = 128'hDEAD_0000_0000_0000_0000_0000_0000_0000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_axi_ar_valid = 1'b0, s_axi_ar_ready;
  logic [AW-1:0] s_axi_ar_bits_addr = '0;
  logic [7:0]    s_axi_ar_bits_len = '0;
  logic [2:0]    s_axi_ar_bits_size = '0, s_axi_ar_bits_prot = '0;
  logic [1:0]    s_axi_ar_bits_burst = '0;
  logic [3:0]    s_axi_ar_bits_cache = '0, s_axi_ar_bits_qos = '0;
  logic          s_axi_ar_bits_lock = 1'b0;
  logic          s_axi_r_valid, s_axi_r_ready = 1'b0;
  logic [DW-1:0] s_axi_r_bits_data;
  logic [1:0]    s_axi_r_bits_resp;
  logic          s_axi_r_bits_last;
  logic          m_axi_ar_valid, m_axi_ar_ready = 1'b0;
  logic [AW-1:0] m_axi_ar_bits_addr;
  logic [7:0]    m_axi_ar_bits_len;
  logic [2:0]    m_axi_ar_bits_size, m_axi_ar_bits_prot;
  logic [1:0]    m_axi_ar_bits_burst;
  logic [3:0]    m_axi_ar_bits_cache, m_axi_ar_bits_qos;
  logic          m_axi_ar_bits_lock;
  logic          m_axi_r_valid = 1'b0, m_axi_r_ready;
  logic [DW-1:0] m_axi_r_bits_data = '0;
  logic [1:0]    m_axi_r_bits_resp = '0;
  logic          m_axi_r_bits_last = 1'b0;
`ifdef RD_SPLITTER_STATS_EN
  logic [31:0]   stat_bursts, stat_splits;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_addr[8];
  logic [7:0]  exp_len[8];
  bit          aborted;

  always #5 clock = ~clock;

  dbchecker_rd_splitter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_axi_ar_valid(s_axi_ar_valid), .s_axi_ar_ready(s_axi_ar_ready),
    .s_axi_ar_bits_addr(s_axi_ar_bits_addr), .s_axi_ar_bits_len(s_axi_ar_bits_len),
    .s_axi_ar_bits_size(s_axi_ar_bits_size), .s_axi_ar_bits_burst(s_axi_ar_bits_burst),
    .s_axi_ar_bits_cache(s_axi_ar_bits_cache), .s_axi_ar_bits_prot(s_axi_ar_bits_prot),
    .s_axi_ar_bits_qos(s_axi_ar_bits_qos), .s_axi_ar_bits_lock(s_axi_ar_bits_lock),
    .s_axi_r_valid(s_axi_r_valid), .s_axi_r_ready(s_axi_r_ready),
    .s_axi_r_bits_data(s_axi_r_bits_data), .s_axi_r_bits_resp(s_axi_r_bits_resp),
    .s_axi_r_bits_last(s_axi_r_bits_last),
    .m_axi_ar_valid(m_axi_ar_valid), .m_axi_ar_ready(m_axi_ar_ready),
    .m_axi_ar_bits_addr(m_axi_ar_bits_addr), .m_axi_ar_bits_len(m_axi_ar_bits_len),
    .m_axi_ar_bits_size(m_axi_ar_bits_size), .m_axi_ar_bits_burst(m_axi_ar_bits_burst),
    .m_axi_ar_bits_cache(m_axi_ar_bits_cache), .m_axi_ar_bits_prot(m_axi_ar_bits_prot),
    .m_axi_ar_bits_qos(m_axi_ar_bits_qos), .m_axi_ar_bits_lock(m_axi_ar_bits_lock),
    .m_axi_r_valid(m_axi_r_valid), .m_axi_r_ready(m_axi_r_ready),
    .m_axi_r_bits_data(m_axi_r_bits_data), .m_axi_r_bits_resp(m_axi_r_bits_resp),
    .m_axi_r_bits_last(m_axi_r_bits_last)
`ifdef RD_SPLITTER_STATS_EN
    ,
    .stat_bursts(stat_bursts), .stat_splits(stat_splits)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream request, then serve each expected sub-burst; abort_at > 0 stops after that beat.
  task automatic do_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int n_ar, input bit stall,
                          input int abort_at, output bit abort_o);
    int          total;
    int          idx;
    bit          hs, seen;
    logic [63:0] cap_addr;
    logic [7:0]  cap_len;
    total   = int'(len) + 1;
    idx     = 0;
    abort_o = 1'b0;
    @(negedge clock);
    s_axi_ar_valid      = 1'b1;
    s_axi_ar_bits_addr  = addr;
    s_axi_ar_bits_len   = len;
    s_axi_ar_bits_size  = size;
    s_axi_ar_bits_burst = burst;
    s_axi_ar_bits_cache = 4'h3;
    s_axi_ar_bits_prot  = 3'h2;
    s_axi_ar_bits_qos   = 4'h1;
    #1 check_eq("s_ar_ready_idle", s_axi_ar_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    s_axi_ar_valid = 1'b0;
    // A stray downstream R beat before the AR is issued must be held off.
    m_axi_r_valid = 1'b1;
    s_axi_r_ready = 1'b1;
    #1;
    check_eq("m_ar_valid_latency", m_axi_ar_valid, 1'b1);
    check_eq("s_ar_ready_busy", s_axi_ar_ready, 1'b0);
    check_eq("m_r_ready_held", m_axi_r_ready, 1'b0);
    check_eq("s_r_valid_held", s_axi_r_valid, 1'b0);
    m_axi_r_valid = 1'b0;
    for (int k = 0; k < n_ar; k++) begin
      seen = 1'b0;
      hs   = 1'b0;
      for (int t = 0; t < 64 && !hs; t++) begin
        m_axi_ar_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (m_axi_ar_valid && !seen) begin
          seen     = 1'b1;
          cap_addr = m_axi_ar_bits_addr;
          cap_len  = m_axi_ar_bits_len;
        end
        if (m_axi_ar_valid && m_axi_ar_ready) begin
          hs = 1'b1;
          if (stall) begin
            check_eq("ar_addr_stable", m_axi_ar_bits_addr, cap_addr);
            check_eq("ar_len_stable", m_axi_ar_bits_len, cap_len);
          end
          check_eq("ar_addr", m_axi_ar_bits_addr, exp_addr[k]);
          check_eq("ar_len", m_axi_ar_bits_len, exp_len[k]);
          check_eq("ar_size", m_axi_ar_bits_size, size);
          check_eq("ar_burst", m_axi_ar_bits_burst, burst);
          check_eq("ar_cache", m_axi_ar_bits_cache, 4'h3);
        end
        @(posedge clock);
        @(negedge clock);
      end
      m_axi_ar_ready = 1'b0;
      if (!hs) begin
        check_eq("ar_timeout", 1'b0, 1'b1);
        return;
      end
      for (int b = 0; b <= int'(exp_len[k]); b++) begin
        hs = 1'b0;
        for (int t = 0; t < 64 && !hs; t++) begin
          m_axi_r_valid     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          m_axi_r_bits_data = DataBase + 128'(idx);
          m_axi_r_bits_last = (b == int'(exp_len[k]));
          m_axi_r_bits_resp = (idx == 5) ? 2'b10 : 2'b00;
          s_axi_r_ready     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          #1;
          if (m_axi_r_valid && s_axi_r_ready) begin
            hs = 1'b1;
            check_eq("r_valid", s_axi_r_valid, 1'b1);
            check_eq("r_ready", m_axi_r_ready, 1'b1);
            check_eq("r_data", s_axi_r_bits_data, DataBase + 128'(idx));
            check_eq("r_resp", s_axi_r_bits_resp, (idx == 5) ? 2'b10 : 2'b00);
            check_eq("r_last", s_axi_r_bits_last, (idx == total - 1));
            idx++;
            if (abort_at > 0 && idx == abort_at) abort_o = 1'b1;
          end
          @(posedge clock);
          @(negedge clock);
          if (abort_o) return;
        end
        if (!hs) begin
          check_eq("r_timeout", 1'b0, 1'b1);
          return;
        end
      end
      m_axi_r_valid = 1'b0;
    end
    m_axi_r_valid = 1'b0;
    s_axi_r_ready = 1'b0;
    #1;
    check_eq("beat_count", idx, total);
    check_eq("back_to_idle", s_axi_ar_ready, 1'b1);
    check_eq("no_extra_ar", m_axi_ar_valid, 1'b0);
  endtask

  initial begin
    #1;
    check_eq("rst_s_ar_ready", s_axi_ar_ready, 1'b0);
    check_eq("rst_m_ar_valid", m_axi_ar_valid, 1'b0);
    check_eq("rst_s_r_valid", s_axi_r_valid, 1'b0);
    check_eq("rst_m_r_ready", m_axi_r_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check_eq("ready_before_edge", s_axi_ar_ready, 1'b0);
    @(posedge clock);
    #1 check_eq("ready_first_edge", s_axi_ar_ready, 1'b1);

    // 64 beats at 16 B split into four 16-beat bursts.
    exp_addr[0] = 64'h1000; exp_addr[1] = 64'h1100; exp_addr[2] = 64'h1200; exp_addr[3] = 64'h1300;
    for (int i = 0; i < 4; i++) exp_len[i] = 8'd15;
    do_burst(64'h1000, 8'd63, 3'd4, 2'b01, 4, 1'b0, 0, aborted);
`ifdef RD_SPLITTER_STATS_EN
    check_eq("stat_bursts", stat_bursts, 32'd1);
    check_eq("stat_splits", stat_splits, 32'd4);
`endif

    // Four beats left in the page at 0xFC0, then the rest at 0x1000.
    exp_addr[0] = 64'h0FC0; exp_len[0] = 8'd3;
    exp_addr[1] = 64'h1000; exp_len[1] = 8'd3;
    do_burst(64'h0FC0, 8'd7, 3'd4, 2'b01, 2, 1'b0, 0, aborted);

    exp_addr[0] = 64'h2008; exp_len[0] = 8'd0;
    do_burst(64'h2008, 8'd0, 3'd4, 2'b01, 1, 1'b0, 0, aborted);

    exp_addr[0] = 64'h3000; exp_len[0] = 8'd31;
    do_burst(64'h3000, 8'd31, 3'd4, 2'b10, 1, 1'b0, 0, aborted);

    exp_addr[0] = 64'h1000; exp_addr[1] = 64'h1100; exp_addr[2] = 64'h1200; exp_addr[3] = 64'h1300;
    for (int i = 0; i < 4; i++) exp_len[i] = 8'd15;
    do_burst(64'h1000, 8'd63, 3'd4, 2'b01, 4, 1'b1, 0, aborted);

    // Reset mid-burst with a downstream beat still offered.
    do_burst(64'h1000, 8'd63, 3'd4, 2'b01, 4, 1'b0, 20, aborted);
    check_eq("abort_reached", aborted, 1'b1);
    m_axi_r_valid = 1'b1;
    s_axi_r_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("abort_m_ar_valid", m_axi_ar_valid, 1'b0);
    check_eq("abort_s_r_valid", s_axi_r_valid, 1'b0);
    check_eq("abort_m_r_ready", m_axi_r_ready, 1'b0);
    check_eq("abort_s_ar_ready", s_axi_ar_ready, 1'b0);
`ifdef RD_SPLITTER_STATS_EN
    check_eq("abort_stat_bursts", stat_bursts, 32'd0);
    check_eq("abort_stat_splits", stat_splits, 32'd0);
`endif
    m_axi_r_valid = 1'b0;
    s_axi_r_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("post_abort_ready", s_axi_ar_ready, 1'b1);
    check_eq("post_abort_ar_valid", m_axi_ar_valid, 1'b0);

    exp_addr[0] = 64'h2008; exp_len[0] = 8'd0;
    do_burst(64'h2008, 8'd0, 3'd4, 2'b01, 1, 1'b0, 0, aborted);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
